// File: rtl/display_scanner_if.sv
// Control and drive bundle between the display scanner and its user.
// master: drives en, digit_enable, brightness; observes the scan outputs.
// slave : the scanner; samples the controls and drives anode, digit_idx, slot_start, frame_done.
interface display_scanner_if #(
  parameter int NUM_DIGITS = 4,
  parameter int PWM_BITS   = 4
);
  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  logic                  en;
  logic [NUM_DIGITS-1:0] digit_enable;
  logic [PWM_BITS-1:0]   brightness;
  logic [NUM_DIGITS-1:0] anode;
  logic [IDX_W-1:0]      digit_idx;
  logic                  slot_start;
  logic                  frame_done;

  modport master (
    output en, digit_enable, brightness,
    input  anode, digit_idx, slot_start, frame_done
  );

  modport slave (
    input  en, digit_enable, brightness,
    output anode, digit_idx, slot_start, frame_done
  );
endinterface

// File: rtl/display_scanner.sv
// Multiplexed seven-segment anode scanner: one slot of REFRESH_DIV clocks per enabled digit,
// with a blank window at slot start and PWM brightness inside the slot.
// Latency: all outputs registered; control inputs reach the anode one edge later. No backpressure.
// Ports: clk, rst (async, active-high); bus (slave) carries en / digit_enable / brightness in and
// anode / digit_idx / slot_start / frame_done out.
module display_scanner #(
  parameter int NUM_DIGITS       = 4,
  parameter int REFRESH_DIV      = 100000,
  parameter int PWM_BITS         = 4,
  parameter int BLANK_CYCLES     = 16,
  parameter int ANODE_ACTIVE_LOW = 1
) (
  input  logic               clk,
  input  logic               rst,
  display_scanner_if.slave   bus
);

  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int CNT_W = $clog2(REFRESH_DIV);
  localparam logic [NUM_DIGITS-1:0] ANODE_OFF =
    (ANODE_ACTIVE_LOW != 0) ? {NUM_DIGITS{1'b1}} : {NUM_DIGITS{1'b0}};

  logic [CNT_W-1:0]      count_q;
  logic [CNT_W-1:0]      count_nxt;
  logic [IDX_W-1:0]      idx_q;
  logic [IDX_W-1:0]      idx_nxt;
  logic [IDX_W-1:0]      next_idx;
  logic [NUM_DIGITS-1:0] anode_q;
  logic [NUM_DIGITS-1:0] anode_nxt;
  logic [NUM_DIGITS-1:0] onehot;
  logic                  slot_start_q;
  logic                  frame_done_q;
  logic                  any_en;
  logic                  wrap;
  logic                  advance;
  logic                  in_window;
  logic                  lit;
  logic [63:0]           on_cycles;

  // Cyclic search for the next enabled digit, starting one past the current one.
  // Offset NUM_DIGITS lands back on the current digit, so a lone enabled digit re-selects itself.
  always_comb begin : next_search
    int  pos;
    logic found;
    pos      = 0;
    found    = 1'b0;
    next_idx = idx_q;
    for (int k = 1; k <= NUM_DIGITS; k++) begin
      pos = (int'(idx_q) + k) % NUM_DIGITS;
      if (!found && bus.digit_enable[pos]) begin
        found    = 1'b1;
        next_idx = IDX_W'(pos);
      end
    end
  end

  assign any_en  = |bus.digit_enable;
  assign wrap    = bus.en && (count_q == CNT_W'(REFRESH_DIV - 1));
  // With no digit enabled the counter still cycles but the index and pulses stay quiet.
  assign advance = wrap && any_en;

  always_comb begin
    count_nxt = count_q;
    if (bus.en) begin
      count_nxt = wrap ? '0 : count_q + CNT_W'(1);
    end
  end

  assign idx_nxt = advance ? next_idx : idx_q;

  // Full-width product before the shift so large dividers keep their precision.
  assign on_cycles = ((64'(bus.brightness) + 64'd1) * 64'(REFRESH_DIV)) >> PWM_BITS;

  // The anode register is loaded from the post-edge count/index so that the anode
  // seen in a cycle matches the count and digit_idx of that same cycle.
  assign in_window = (64'(count_nxt) >= 64'(BLANK_CYCLES)) && (64'(count_nxt) < on_cycles);
  assign lit       = bus.en && bus.digit_enable[idx_nxt] && in_window;

  always_comb begin
    onehot = '0;
    if (lit) begin
      onehot[idx_nxt] = 1'b1;
    end
    anode_nxt = (ANODE_ACTIVE_LOW != 0) ? ~onehot : onehot;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q      <= '0;
      idx_q        <= '0;
      anode_q      <= ANODE_OFF;
      slot_start_q <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      count_q      <= count_nxt;
      idx_q        <= idx_nxt;
      anode_q      <= anode_nxt;
      slot_start_q <= advance;
      // Wrap detection: the new index is not beyond the old one.
      frame_done_q <= advance && (next_idx <= idx_q);
    end
  end

  assign bus.anode      = anode_q;
  assign bus.digit_idx  = idx_q;
  assign bus.slot_start = slot_start_q;
  assign bus.frame_done = frame_done_q;

endmodule

// File: tb/tb_display_scanner.sv
// Directed bench for display_scanner (4 digits, 8-cycle slots, 2-bit PWM, 1-cycle blank,
// active-low anodes). Expected outputs are queued when each edge is stimulated and popped
// once the DUT has updated; extra directed checks use literal values.
module tb_display_scanner;

  typedef struct packed {
    logic [3:0] anode;
    logic [1:0] idx;
    logic       ss;
    logic       fd;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   compared   = 0;
  int   mismatched = 0;
  int   m_cnt = 0;
  int   m_idx = 0;
  exp_t sb_q[$];

  display_scanner_if #(.NUM_DIGITS(4), .PWM_BITS(2)) bus ();

  display_scanner #(
    .NUM_DIGITS(4), .REFRESH_DIV(8), .PWM_BITS(2),
    .BLANK_CYCLES(1), .ANODE_ACTIVE_LOW(1)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance the reference by one edge, queue its prediction, clock the DUT, then compare.
  task automatic step();
    exp_t       e;
    logic [3:0] de;
    logic [3:0] hot;
    int         on;
    int         nx;
    bit         found;
    de      = bus.digit_enable;
    e       = '0;
    if (bus.en) begin
      if (m_cnt == 7) begin
        m_cnt = 0;
        if (de != 4'b0000) begin
          found = 0;
          nx    = m_idx;
          for (int k = 1; k <= 4; k++) begin
            if (!found && de[(m_idx + k) % 4]) begin
              found = 1;
              nx    = (m_idx + k) % 4;
            end
          end
          e.ss  = 1'b1;
          e.fd  = (nx <= m_idx);
          m_idx = nx;
        end
      end else begin
        m_cnt++;
      end
    end
    on      = 2 * (int'(bus.brightness) + 1);
    hot     = 4'b0001 << m_idx;
    e.anode = (bus.en && de[m_idx] && m_cnt >= 1 && m_cnt < on) ? ~hot : 4'hF;
    e.idx   = 2'(m_idx);
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    e = sb_q.pop_front();
    chk("anode", 32'(bus.anode), 32'(e.anode));
    chk("digit_idx", 32'(bus.digit_idx), 32'(e.idx));
    chk("slot_start", 32'(bus.slot_start), 32'(e.ss));
    chk("frame_done", 32'(bus.frame_done), 32'(e.fd));
    chk("one_hot", 32'($countones(~bus.anode) <= 1), 32'd1);
  endtask

  initial begin
    int   lows;
    int   fds;
    int   ss_cnt;
    int   bad;
    int   n;
    logic [7:0] seq;

    bus.en           = 1'b1;
    bus.digit_enable = 4'b1111;
    bus.brightness   = 2'd3;
    rst              = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst   = 1'b0;
    m_cnt = 0;
    m_idx = 0;
    chk("reset_anode", 32'(bus.anode), 32'hF);
    chk("reset_idx", 32'(bus.digit_idx), 32'd0);
    chk("reset_ss", 32'(bus.slot_start), 32'd0);
    chk("reset_fd", 32'(bus.frame_done), 32'd0);

    // 1: full brightness, all digits
    fds = 0;
    for (int c = 1; c <= 32; c++) begin
      step();
      if (bus.frame_done) fds++;
      if (c == 1) chk("t1_first_lit", 32'(bus.anode), 32'hE);
      if (c == 7) chk("t1_last_lit", 32'(bus.anode), 32'hE);
      if (c == 8) begin
        chk("t1_ss_slot1", 32'(bus.slot_start), 32'd1);
        chk("t1_idx_slot1", 32'(bus.digit_idx), 32'd1);
        chk("t1_blank_slot1", 32'(bus.anode), 32'hF);
      end
      if (c == 32) chk("t1_idx_wrap", 32'(bus.digit_idx), 32'd0);
    end
    chk("t1_frame_count", 32'(fds), 32'd1);

    // 2: brightness 0 then 1
    bus.brightness = 2'd0;
    lows = 0;
    repeat (16) begin
      step();
      if (bus.anode != 4'hF) lows++;
    end
    chk("t2_br0_lit_cycles", 32'(lows), 32'd2);
    bus.brightness = 2'd1;
    lows = 0;
    repeat (16) begin
      step();
      if (bus.anode != 4'hF) lows++;
    end
    chk("t2_br1_lit_cycles", 32'(lows), 32'd6);

    // 3: sparse enable 1010
    bus.brightness   = 2'd3;
    bus.digit_enable = 4'b1010;
    seq = '0;
    fds = 0;
    bad = 0;
    for (int c = 1; c <= 32; c++) begin
      step();
      if (bus.frame_done) fds++;
      if (bus.slot_start) seq = {seq[5:0], bus.digit_idx};
      if (c >= 8 && (bus.anode[0] == 1'b0 || bus.anode[2] == 1'b0)) bad++;
    end
    chk("t3_idx_seq", 32'(seq), 32'b01_11_01_11);
    chk("t3_frame_count", 32'(fds), 32'd1);
    chk("t3_dark_digits", 32'(bad), 32'd0);

    // 4: all digits disabled mid-scan
    repeat (3) step();
    bus.digit_enable = 4'b0000;
    ss_cnt = 0;
    bad    = 0;
    repeat (12) begin
      step();
      if (bus.slot_start || bus.frame_done) ss_cnt++;
      if (bus.anode != 4'hF) bad++;
    end
    chk("t4_no_pulses", 32'(ss_cnt), 32'd0);
    chk("t4_all_off", 32'(bad), 32'd0);
    chk("t4_idx_frozen", 32'(bus.digit_idx), 32'd3);
    bus.digit_enable = 4'b0100;
    n = 0;
    do begin
      step();
      n++;
    end while (!bus.slot_start && n < 16);
    chk("t4_restore_idx", 32'(bus.digit_idx), 32'd2);

    // 5: en low for 10 cycles at count 5
    n = 0;
    while (m_cnt != 5 && n < 16) begin
      step();
      n++;
    end
    bus.en = 1'b0;
    bad    = 0;
    repeat (10) begin
      step();
      if (bus.anode != 4'hF || bus.slot_start) bad++;
    end
    chk("t5_frozen_dark", 32'(bad), 32'd0);
    chk("t5_idx_frozen", 32'(bus.digit_idx), 32'd2);
    bus.en = 1'b1;
    n = 0;
    do begin
      step();
      n++;
    end while (!bus.slot_start && n < 20);
    chk("t5_resume_cycles", 32'(n), 32'd3);

    // 6: asynchronous reset mid-cycle at count 4, idx 2
    n = 0;
    while (m_cnt != 4 && n < 16) begin
      step();
      n++;
    end
    chk("t6_lit_before_rst", 32'(bus.anode), 32'hB);
    #2;
    rst = 1'b1;
    #1;
    chk("t6_rst_anode", 32'(bus.anode), 32'hF);
    chk("t6_rst_idx", 32'(bus.digit_idx), 32'd0);
    chk("t6_rst_ss", 32'(bus.slot_start), 32'd0);
    chk("t6_rst_fd", 32'(bus.frame_done), 32'd0);
    #1;
    rst   = 1'b0;
    m_cnt = 0;
    m_idx = 0;
    bad   = 0;
    repeat (7) begin
      step();
      if (bus.digit_idx != 2'd0 || bus.anode != 4'hF) bad++;
    end
    chk("t6_slot0_dark", 32'(bad), 32'd0);
    step();
    chk("t6_next_idx", 32'(bus.digit_idx), 32'd2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
